// File: rtl/rom_loader_pkg.sv
// Shared encodings for the boot ROM loader.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package rom_loader_pkg;

  // Loader sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bytes per memory word and the address bits that select a byte lane
  localparam int WORD_BYTES = 4;
  localparam int LANE_BITS  = 2;

endpackage

// File: rtl/rom_word_packer.sv
// Packs ROM bytes into one little-endian memory word, one lane per write.
// Latency: a byte written at a rising edge is visible on o_word right after it.
// Backpressure: none; the owner simply stops writing while the word is held.
module rom_word_packer
  import rom_loader_pkg::*;
(
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_clear,
  input  logic                    i_write,
  input  logic [LANE_BITS-1:0]    i_lane,
  input  logic [7:0]              i_byte,
  output logic [8*WORD_BYTES-1:0] o_word
);

  logic [8*WORD_BYTES-1:0] r_word;

  // Clear wins over a lane write so a new word always starts from zero lanes
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_word <= '0;
    end else if (i_clear) begin
      r_word <= '0;
    end else if (i_write) begin
      r_word[{i_lane, 3'b000} +: 8] <= i_byte;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/rom_loader.sv
// Walks the program ROM from byte 0 and writes packed 32-bit words to main memory.
// Latency: one byte per cycle, plus one WRITE cycle per word when ready is high (5 cycles per full word).
// Backpressure: WRITE holds address, data and the ROM pointer steady until mem_write_ready.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_BYTES  = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [7:0]            rom_byte,
  input  logic                  rom_done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data,
  output logic                  mem_write_valid,
  input  logic                  mem_write_ready,
  output logic                  busy,
  output logic                  load_complete,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] bytes_loaded
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_rom_address;
  logic [ADDR_WIDTH-1:0] r_word_index;
  logic [ADDR_WIDTH-1:0] r_bytes_loaded;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic                  r_last;
  logic                  r_overflow;
  logic                  r_mem_write_valid;
  logic                  r_busy;
  logic                  r_load_complete;

  logic [LANE_BITS-1:0]  w_lane;
  logic [ADDR_WIDTH-1:0] w_bytes_next;
  logic                  w_limit_hit;
  logic                  w_last;
  logic                  w_start_load;
  logic                  w_handshake;
  logic                  w_capture;
  logic                  w_clear;
  logic [31:0]           w_word;

  assign w_lane       = r_rom_address[LANE_BITS-1:0];
  assign w_bytes_next = r_bytes_loaded + ADDR_WIDTH'(1);
  assign w_limit_hit  = (w_bytes_next == ADDR_WIDTH'(MAX_BYTES));
  assign w_last       = rom_done || w_limit_hit;
  assign w_start_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_handshake  = (r_state == ST_WRITE) && mem_write_ready;
  assign w_capture    = (r_state == ST_FETCH);
  // The final word is kept after the last handshake so DONE still shows it
  assign w_clear      = w_start_load || (w_handshake && !r_last);

  rom_word_packer u_packer (
    .i_clock (clock),
    .i_reset (reset),
    .i_clear (w_clear),
    .i_write (w_capture),
    .i_lane  (w_lane),
    .i_byte  (rom_byte),
    .o_word  (w_word)
  );

  // Load sequencer: counters, word address and handshake outputs are all registered here
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state           <= ST_IDLE;
      r_rom_address     <= '0;
      r_word_index      <= '0;
      r_bytes_loaded    <= '0;
      r_mem_address     <= '0;
      r_last            <= 1'b0;
      r_overflow        <= 1'b0;
      r_mem_write_valid <= 1'b0;
      r_busy            <= 1'b0;
      r_load_complete   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state         <= ST_FETCH;
            r_rom_address   <= '0;
            r_word_index    <= '0;
            r_bytes_loaded  <= '0;
            r_mem_address   <= '0;
            r_last          <= 1'b0;
            r_overflow      <= 1'b0;
            r_busy          <= 1'b1;
            r_load_complete <= 1'b0;
          end
        end

        ST_FETCH: begin
          r_bytes_loaded <= w_bytes_next;
          // A real end of ROM on the same byte as the limit is not an overflow
          r_overflow     <= !rom_done && w_limit_hit;
          r_last         <= w_last;
          if (w_last || (w_lane == LANE_BITS'(WORD_BYTES - 1))) begin
            r_state           <= ST_WRITE;
            r_mem_write_valid <= 1'b1;
            r_mem_address     <= BASE_ADDR + (r_word_index << LANE_BITS);
          end else begin
            r_rom_address <= r_rom_address + ADDR_WIDTH'(1);
          end
        end

        ST_WRITE: begin
          if (mem_write_ready) begin
            r_mem_write_valid <= 1'b0;
            if (r_last) begin
              r_state         <= ST_DONE;
              r_busy          <= 1'b0;
              r_load_complete <= 1'b1;
            end else begin
              r_state       <= ST_FETCH;
              r_word_index  <= r_word_index + ADDR_WIDTH'(1);
              r_rom_address <= r_rom_address + ADDR_WIDTH'(1);
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rom_address     = r_rom_address;
  assign mem_address     = r_mem_address;
  assign mem_data        = w_word;
  assign mem_write_valid = r_mem_write_valid;
  assign busy            = r_busy;
  assign load_complete   = r_load_complete;
  assign overflow        = r_overflow;
  assign bytes_loaded    = r_bytes_loaded;

endmodule
